// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one fifo write port among NUM_REQ producers
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0]   req_data,
   input  logic                              full,
   output logic                              wr,
   output logic [2*DATA_WIDTH-1:0]           w_data,
   output logic [NUM_REQ-1:0]                gnt,
   output logic [$clog2(NUM_REQ)-1:0]        owner,
   output logic                              busy,
   output logic [15:0]                       stall_cnt
);
   localparam int WW = 2*DATA_WIDTH;
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_LEN+1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t          state, state_nx;
   logic [IW-1:0]   owner_nx, winner, sel;
   logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
   logic [15:0]     stall_nx;
   logic            found, want, do_wr;
   // round-robin search starting just after the last owner
   always_comb begin
      found  = 1'b0;
      winner = owner;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (int'(owner) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IW'(idx);
         end
      end
   end
   // write port drive: only the burst owner is eligible while busy, full blocks everything
   always_comb begin
      want   = (state == IDLE) ? found : req[owner];
      sel    = (state == IDLE) ? winner : owner;
      do_wr  = reset & want & ~full;
      wr     = do_wr;
      gnt    = do_wr ? (NUM_REQ'(1) << sel) : '0;
      w_data = do_wr ? req_data[int'(sel)*WW +: WW] : '0;
      busy   = (state == BURST);
   end
   // next-state, owner, burst count and saturating stall count
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      cnt_nx   = cnt;
      cnt_inc  = cnt + CW'(1);
      stall_nx = (reset & want & full & (stall_cnt != 16'hFFFF)) ? stall_cnt + 16'd1 : stall_cnt;
      if (state == IDLE) begin
         if (do_wr) begin
            owner_nx = winner;
            cnt_nx   = CW'(1);
            state_nx = (BURST_LEN > 1) ? BURST : IDLE;
         end
      end else if (!req[owner]) begin
         state_nx = IDLE;
      end else if (do_wr) begin
         cnt_nx   = cnt_inc;
         state_nx = (cnt_inc == CW'(BURST_LEN)) ? IDLE : BURST;
      end
   end
   // state registers; reset leaves owner at the last producer so producer 0 wins first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= IW'(NUM_REQ-1);
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         cnt       <= cnt_nx;
         stall_cnt <= stall_nx;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic        full;
   logic        wr;
   logic [15:0] w_data;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;
   logic [15:0] stall_cnt;
   int          passed = 0;
   int          total  = 0;
   fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST_LEN(2)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .full(full),
      .wr(wr), .w_data(w_data), .gnt(gnt), .owner(owner), .busy(busy), .stall_cnt(stall_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic do_rst();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      #1;
   endtask
   initial begin
      logic [3:0] order [9];
      logic [15:0] words [4];
      logic       bseq [3];
      order = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
      words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      bseq  = '{1'b0, 1'b1, 1'b0};
      reset    = 1'b0;
      req      = 4'hF;
      full     = 1'b0;
      req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr", 32'(wr), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_wdata", 32'(w_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      reset = 1'b1;
      #1;
      chk("first_gnt", 32'(gnt), 32'b0001);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("all_wr%0d", i), 32'(wr), 32'd1);
         chk($sformatf("all_gnt%0d", i), 32'(gnt), 32'(order[i]));
         chk($sformatf("all_data%0d", i), 32'(w_data), 32'(words[$clog2(order[i])]));
         cyc();
      end
      req = 4'b0000;
      req_data[2*16 +: 16] = 16'haabb;
      do_rst();
      req = 4'b0100;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("single_wr%0d", i), 32'(wr), 32'd1);
         chk($sformatf("single_gnt%0d", i), 32'(gnt), 32'b0100);
         chk($sformatf("single_data%0d", i), 32'(w_data), 32'haabb);
         chk($sformatf("single_busy%0d", i), 32'(busy), 32'(bseq[i]));
         cyc();
      end
      req = 4'b0010;
      full = 1'b1;
      req_data[1*16 +: 16] = 16'h5678;
      do_rst();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("full_wr%0d", i), 32'(wr), 32'd0);
         chk($sformatf("full_gnt%0d", i), 32'(gnt), 32'd0);
         cyc();
      end
      chk("full_stall", 32'(stall_cnt), 32'd3);
      full = 1'b0;
      #1;
      chk("full_rel_wr", 32'(wr), 32'd1);
      chk("full_rel_gnt", 32'(gnt), 32'b0010);
      chk("full_rel_data", 32'(w_data), 32'h5678);
      req = 4'b1001;
      req_data[0 +: 16]    = 16'hcdef;
      req_data[3*16 +: 16] = 16'h26a7;
      do_rst();
      chk("drop_gnt0", 32'(gnt), 32'b0001);
      chk("drop_data0", 32'(w_data), 32'hcdef);
      cyc();
      chk("drop_busy", 32'(busy), 32'd1);
      chk("drop_owner", 32'(owner), 32'd0);
      req = 4'b1000;
      #1;
      chk("drop_bubble_wr", 32'(wr), 32'd0);
      chk("drop_bubble_gnt", 32'(gnt), 32'd0);
      cyc();
      chk("drop_idle", 32'(busy), 32'd0);
      chk("drop_gnt3", 32'(gnt), 32'b1000);
      chk("drop_data3", 32'(w_data), 32'h26a7);
      chk("drop_nostall", 32'(stall_cnt), 32'd0);
      req = 4'b0011;
      do_rst();
      chk("bfull_gnt0", 32'(gnt), 32'b0001);
      cyc();
      full = 1'b1;
      #1;
      chk("bfull_wr", 32'(wr), 32'd0);
      cyc();
      chk("bfull_busy", 32'(busy), 32'd1);
      chk("bfull_stall", 32'(stall_cnt), 32'd1);
      full = 1'b0;
      #1;
      chk("bfull_owner_gnt", 32'(gnt), 32'b0001);
      cyc();
      chk("bfull_next_gnt", 32'(gnt), 32'b0010);
      req = 4'b0100;
      do_rst();
      cyc();
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_owner", 32'(owner), 32'd2);
      reset = 1'b0;
      #1;
      chk("mid_wr", 32'(wr), 32'd0);
      chk("mid_gnt", 32'(gnt), 32'd0);
      chk("mid_data", 32'(w_data), 32'd0);
      chk("mid_busy0", 32'(busy), 32'd0);
      chk("mid_owner_rst", 32'(owner), 32'd3);
      req = 4'b0101;
      cyc();
      reset = 1'b1;
      #1;
      chk("mid_first_gnt", 32'(gnt), 32'b0001);
      req = 4'b0010;
      full = 1'b1;
      do_rst();
      repeat (65535) @(posedge clk);
      #1;
      chk("sat_max", 32'(stall_cnt), 32'hFFFF);
      cyc();
      chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
